video_modeswitch: RTL and testbench

- Sequences TV/VGA output-mode changes for the video output multiplexer.
- Takes the requested mode from the config register path and waits for a vertical-sync boundary.
- Blanks the picture for a programmable number of frames, flips the `vga_on` select, then blanks for further frames before unblanking.
- Sits between the config registers and the output mux. It drives that mux's `vga_on` input and a `blank` gate that forces colour to zero.

---
 rtl/video_modeswitch_pkg.sv | 15 +
 rtl/video_modeswitch_if.sv | 27 ++
 rtl/video_frame_strobe.sv | 40 ++++
 rtl/video_modeswitch.sv | 111 +++++++++++
 tb/tb_video_modeswitch.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/video_modeswitch_pkg.sv
// Shared encodings for the TV/VGA output-mode switch sequencer.
// Reused by any frame-synchronised controller that adopts the same state names.
package video_modeswitch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    PRE       = 2'd2,
    POST      = 2'd3
  } ms_state_e;

  localparam logic MODE_TV  = 1'b0;
  localparam logic MODE_VGA = 1'b1;

endpackage

// File: rtl/video_modeswitch_if.sv
// Signal bundle between the config registers, the mode-switch sequencer
// and the output mux.
interface video_modeswitch_if;
  import video_modeswitch_pkg::*;

  // Handshake: req_vga is a level. While busy is low, a difference between
  // req_vga and vga_on starts a sequence; busy stays high until the single
  // cycle in which done pulses. vga_on and blank only move on frame boundaries.
  logic      req_vga;
  logic      vsync;
  logic      vga_on;
  logic      blank;
  logic      busy;
  logic      done;
  ms_state_e state_dbg;

  modport master (
    output req_vga, vsync,
    input  vga_on, blank, busy, done, state_dbg
  );

  modport slave (
    input  req_vga, vsync,
    output vga_on, blank, busy, done, state_dbg
  );

endinterface

// File: rtl/video_frame_strobe.sv
// One-cycle frame-boundary strobe: registered vsync leading edge, or a
// synthetic boundary when no edge arrives within TIMEOUT cycles.
module video_frame_strobe #(
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter logic [19:0] TIMEOUT      = 20'd700000
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic clr,
  output logic fb
);

  localparam logic VS_IDLE = ~VSYNC_ACTIVE;

  logic        vs_r;
  logic        vs_d;
  logic [19:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r  <= VS_IDLE;
      vs_d  <= VS_IDLE;
      timer <= '0;
    end else begin
      vs_r <= vsync;
      vs_d <= vs_r;
      if (clr || fb) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 20'd1;
      end
    end
  end

  // A stopped sync generator still yields one boundary every TIMEOUT cycles.
  assign fb = ((vs_r == VSYNC_ACTIVE) && (vs_d != VSYNC_ACTIVE)) ||
              (timer == TIMEOUT - 20'd1);

endmodule

// File: rtl/video_modeswitch.sv
// Sequences a TV/VGA select change: wait for a frame boundary, blank for
// BLANK_PRE frames, flip vga_on, blank for BLANK_POST frames, unblank.
module video_modeswitch
  import video_modeswitch_pkg::*;
#(
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter int          BLANK_PRE    = 2,
  parameter int          BLANK_POST   = 2,
  parameter logic [19:0] TIMEOUT      = 20'd700000
) (
  input logic               clk,
  input logic               rst,
  video_modeswitch_if.slave vif
);

  if (BLANK_PRE < 1 || BLANK_PRE > 15) begin : g_bad_pre
    $error("video_modeswitch: BLANK_PRE must be within 1..15");
  end
  if (BLANK_POST < 1 || BLANK_POST > 15) begin : g_bad_post
    $error("video_modeswitch: BLANK_POST must be within 1..15");
  end

  localparam logic [3:0] PRE_LAST  = 4'(BLANK_PRE - 1);
  localparam logic [3:0] POST_LAST = 4'(BLANK_POST - 1);

  ms_state_e  state;
  logic [3:0] cnt;
  logic       target;
  logic       req_r;
  logic       vga_on;
  logic       blank;
  logic       busy;
  logic       done;
  logic       fb;

  // The timer only runs while a sequence is in flight; every non-IDLE state
  // change coincides with fb, which clears it anyway.
  video_frame_strobe #(
    .VSYNC_ACTIVE (VSYNC_ACTIVE),
    .TIMEOUT      (TIMEOUT)
  ) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .vsync (vif.vsync),
    .clr   (state == IDLE),
    .fb    (fb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= MODE_TV;
      req_r  <= MODE_TV;
      vga_on <= MODE_TV;
      blank  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      req_r <= vif.req_vga;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_r != vga_on) begin
            target <= req_r;
            busy   <= 1'b1;
            state  <= WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          if (fb) begin
            blank <= 1'b1;
            cnt   <= '0;
            state <= PRE;
          end
        end
        PRE: begin
          if (fb) begin
            if (cnt == PRE_LAST) begin
              vga_on <= target;
              cnt    <= '0;
              state  <= POST;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        POST: begin
          if (fb) begin
            if (cnt == POST_LAST) begin
              blank <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vif.vga_on    = vga_on;
  assign vif.blank     = blank;
  assign vif.busy      = busy;
  assign vif.done      = done;
  assign vif.state_dbg = state;

endmodule

// File: tb/tb_video_modeswitch.sv
// Bench for video_modeswitch: directed scenarios plus random request/reset/vsync
// traffic, every cycle compared against a frame-counting reference model.
module tb_video_modeswitch;
  import video_modeswitch_pkg::*;

  localparam logic VS_ACT    = 1'b0;
  localparam int   PRE       = 2;
  localparam int   POST      = 1;
  localparam int   TMO       = 1000;
  localparam int   VS_PERIOD = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_modeswitch_if vif();

  video_modeswitch #(
    .VSYNC_ACTIVE (VS_ACT),
    .BLANK_PRE    (PRE),
    .BLANK_POST   (POST),
    .TIMEOUT      (20'd1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int vs_mode  = 0;  // 0 running, 1 held inactive, 2 held active
  int vs_ph    = 0;
  int vs_w     = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- vsync driver ----------------
  initial begin
    vif.vsync = ~VS_ACT;
    forever begin
      @(negedge clk);
      case (vs_mode)
        0: begin
          if (vs_ph == 0) vs_w = $urandom_range(2, 8);
          vif.vsync = (vs_ph < vs_w) ? VS_ACT : ~VS_ACT;
          vs_ph = (vs_ph + 1) % VS_PERIOD;
        end
        1:       vif.vsync = ~VS_ACT;
        default: vif.vsync = VS_ACT;
      endcase
    end
  end

  // ---------------- reference model ----------------
  // Counts frame boundaries since a sequence started: boundary 1 blanks,
  // boundary 1+PRE flips the mode, boundary 1+PRE+POST unblanks.
  bit m_vga, m_blank, m_busy, m_done, m_active, m_tgt, m_req;
  bit samp1, samp2, ev, bnd;
  int m_frames, m_since;
  logic [3:0] exp_q[$];

  task automatic model_step();
    if (rst) begin
      m_vga = 0; m_blank = 0; m_busy = 0; m_done = 0; m_active = 0;
      m_tgt = 0; m_req = 0; m_frames = 0; m_since = 0;
      samp1 = ~VS_ACT; samp2 = ~VS_ACT;
    end else begin
      ev  = (samp1 == VS_ACT) && (samp2 != VS_ACT);
      bnd = m_active && (ev || (m_since == TMO - 1));
      m_since = (!m_active || bnd) ? 0 : m_since + 1;
      m_done = 0;
      if (!m_active) begin
        if (m_req != m_vga) begin
          m_active = 1; m_tgt = m_req; m_frames = 0; m_busy = 1;
        end
      end else if (bnd) begin
        m_frames++;
        if (m_frames == 1) m_blank = 1;
        if (m_frames == 1 + PRE) m_vga = m_tgt;
        if (m_frames == 1 + PRE + POST) begin
          m_blank = 0; m_busy = 0; m_done = 1; m_active = 0;
        end
      end
      samp2 = samp1;
      samp1 = vif.vsync;
      m_req = vif.req_vga;
    end
    exp_q.push_back({m_vga, m_blank, m_busy, m_done});
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    logic [3:0] got;
    logic [3:0] exp;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      got = {vif.vga_on, vif.blank, vif.busy, vif.done};
      exp = exp_q.pop_front();
      check("outputs", 32'(got), 32'(exp));
      if (vif.done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // sel: 0 busy, 1 blank, 2 vga_on, 3 done; cyc = negedges until seen.
  task automatic wait_until(input string tag, input int sel, input logic val,
                            input int budget, output int cyc);
    logic s;
    s = 1'bx;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      case (sel)
        0:       s = vif.busy;
        1:       s = vif.blank;
        2:       s = vif.vga_on;
        default: s = vif.done;
      endcase
      if (s === val) return;
    end
    check({tag, "_timeout"}, 32'(s), 32'(val));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int d0;
    vif.req_vga = MODE_TV;
    rst = 1'b1;
    idle_cycles(5);
    rst = 1'b0;

    // Quiet after reset
    idle_cycles(300);
    check("rst_vga_on", 32'(vif.vga_on), 32'(MODE_TV));
    check("rst_blank", 32'(vif.blank), 0);
    check("rst_busy", 32'(vif.busy), 0);
    check("rst_done_cnt", 32'(done_cnt), 0);

    // TV -> VGA with running vsync
    vif.req_vga = MODE_VGA;
    wait_until("busy_up", 0, 1'b1, 20, c);
    check("busy_latency", 32'(c), 2);
    wait_until("blank_up", 1, 1'b1, 600, c);
    wait_until("vga_up", 2, 1'b1, 1000, c);
    check("pre_len", 32'(c), 32'(PRE * VS_PERIOD));
    check("pre_blank", 32'(vif.blank), 1);
    wait_until("done_up", 3, 1'b1, 1000, c);
    check("post_len", 32'(c), 32'(POST * VS_PERIOD));
    check("done_blank", 32'(vif.blank), 0);
    check("done_busy", 32'(vif.busy), 0);

    // VGA -> TV with vsync stopped: timeout-paced frames
    vs_mode = 1;
    vif.req_vga = MODE_TV;
    wait_until("tmo_busy", 0, 1'b1, 20, c);
    wait_until("tmo_blank", 1, 1'b1, 2 * TMO, c);
    check("tmo_first", 32'(c), 32'(TMO));
    wait_until("tmo_flip", 2, 1'b0, 4 * TMO, c);
    check("tmo_pre", 32'(c), 32'(PRE * TMO));
    wait_until("tmo_done", 3, 1'b1, 2 * TMO, c);
    check("tmo_post", 32'(c), 32'(POST * TMO));

    // Request withdrawn mid-PRE: sequence completes, then reverses
    vs_mode = 0;
    vif.req_vga = MODE_VGA;
    wait_until("mid_busy", 0, 1'b1, 20, c);
    wait_until("mid_blank", 1, 1'b1, 600, c);
    idle_cycles($urandom_range(20, 380));
    vif.req_vga = MODE_TV;
    wait_until("mid_done", 3, 1'b1, 1000, c);
    check("mid_vga_on", 32'(vif.vga_on), 32'(MODE_VGA));
    idle_cycles(1);
    check("mid_rebusy", 32'(vif.busy), 1);
    wait_until("mid_idle", 0, 1'b0, 1500, c);
    check("mid_final_vga", 32'(vif.vga_on), 32'(MODE_TV));

    // Reset pulse during POST
    vif.req_vga = MODE_VGA;
    wait_until("post_flip", 2, 1'b1, 1500, c);
    idle_cycles($urandom_range(5, 150));
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    check("abort_vga_on", 32'(vif.vga_on), 32'(MODE_TV));
    check("abort_blank", 32'(vif.blank), 0);
    check("abort_busy", 32'(vif.busy), 0);
    idle_cycles(1);
    check("abort_busy_r1", 32'(vif.busy), 0);
    idle_cycles(1);
    check("abort_busy_r2", 32'(vif.busy), 1);
    wait_until("abort_idle", 0, 1'b0, 1500, c);
    check("abort_final_vga", 32'(vif.vga_on), 32'(MODE_VGA));

    // Short request glitch while busy
    vif.req_vga = MODE_TV;
    wait_until("gl_busy0", 0, 1'b1, 20, c);
    wait_until("gl_idle0", 0, 1'b0, 1500, c);
    vif.req_vga = MODE_VGA;
    wait_until("gl_busy", 0, 1'b1, 20, c);
    idle_cycles($urandom_range(10, 300));
    d0 = done_cnt;
    vif.req_vga = MODE_TV;
    idle_cycles($urandom_range(1, 3));
    vif.req_vga = MODE_VGA;
    wait_until("gl_idle", 0, 1'b0, 1500, c);
    idle_cycles(300);
    check("gl_done_cnt", 32'(done_cnt - d0), 1);
    check("gl_vga_on", 32'(vif.vga_on), 32'(MODE_VGA));
    check("gl_busy_after", 32'(vif.busy), 0);

    // Random traffic: request toggles, glitches, resets, vsync modes
    for (int it = 0; it < 12; it++) begin
      int r;
      r = $urandom_range(0, 9);
      vs_mode = ($urandom_range(0, 5) == 0) ? 2 : 0;
      if (r < 6) begin
        vif.req_vga = ~vif.req_vga;
      end else if (r < 8) begin
        vif.req_vga = ~vif.req_vga;
        idle_cycles($urandom_range(1, 4));
        vif.req_vga = ~vif.req_vga;
      end else begin
        rst = 1'b1;
        idle_cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      idle_cycles($urandom_range(20, 900));
    end
    vs_mode = 0;
    wait_until("rand_settle", 0, 1'b0, 8000, c);
    idle_cycles(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
